// File: rtl/sd_spi_sequencer.sv
// SD session controller: runs the card initializer, then reads NUM_BLOCKS
// consecutive blocks with the reader. It owns the SPI bus, handing CS/MOSI
// to whichever engine is active, and paces each read until the UART FIFO drains.
module sd_spi_sequencer #(
    parameter int                    NUM_BLOCKS  = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter int                    ADDR_STEP   = 512,
    parameter int                    TIMEOUT     = 65535,
    parameter int                    MAX_RETRIES = 3
) (
    input  logic                  d_clock,
    input  logic                  reset_PB_down,
    input  logic                  start,
    input  logic                  card_ready,
    input  logic                  init_MOSI,
    input  logic                  init_CS,
    input  logic                  reader_MOSI,
    input  logic                  reader_CS,
    input  logic                  reader_busy,
    input  logic                  fifo_empty,
    output logic                  sub_reset,
    output logic                  init_start,
    output logic                  reader_start,
    output logic [ADDR_WIDTH-1:0] block_addr,
    output logic                  CS,
    output logic                  MOSI,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SUBRST     = 4'd1,
        S_INIT_START = 4'd2,
        S_INIT_WAIT  = 4'd3,
        S_READ_START = 4'd4,
        S_READ_ARM   = 4'd5,
        S_READ_WAIT  = 4'd6,
        S_DRAIN      = 4'd7,
        S_NEXT       = 4'd8,
        S_DONE       = 4'd9,
        S_ERROR      = 4'd15
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP_W      = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [15:0]           TIMEOUT_W   = 16'(TIMEOUT);
    localparam logic [7:0]            LAST_BLK    = 8'(NUM_BLOCKS - 1);
    localparam logic [7:0]            MAX_RETRY_W = 8'(MAX_RETRIES);

    state_t      cur_state;
    logic [7:0]  blk_cnt;
    logic [7:0]  retry;
    logic [15:0] tcnt;
    logic [15:0] tcnt_inc;
    logic        timed_out;

    // The wait counter sticks at all-ones rather than wrapping back to zero.
    assign tcnt_inc  = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;
    assign timed_out = (tcnt == TIMEOUT_W);
    assign state     = cur_state;

    // Session sequencing: init with bounded retry, then one read per block with drain throttling.
    always_ff @(posedge d_clock or posedge reset_PB_down) begin
        if (reset_PB_down) begin
            cur_state  <= S_IDLE;
            block_addr <= START_ADDR;
            blk_cnt    <= 8'd0;
            retry      <= 8'd0;
            tcnt       <= 16'd0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (start) begin
                        retry      <= 8'd0;
                        blk_cnt    <= 8'd0;
                        block_addr <= START_ADDR;
                        cur_state  <= S_SUBRST;
                    end
                end
                S_SUBRST: cur_state <= S_INIT_START;
                S_INIT_START: begin
                    tcnt      <= 16'd0;
                    cur_state <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (card_ready) begin
                        cur_state <= S_READ_START;
                    end else if (timed_out) begin
                        if (retry < MAX_RETRY_W) begin
                            retry     <= retry + 8'd1;
                            cur_state <= S_SUBRST;
                        end else begin
                            cur_state <= S_ERROR;
                        end
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_READ_START: begin
                    tcnt      <= 16'd0;
                    cur_state <= S_READ_ARM;
                end
                S_READ_ARM: begin
                    if (reader_busy) begin
                        tcnt      <= 16'd0;
                        cur_state <= S_READ_WAIT;
                    end else if (timed_out) begin
                        cur_state <= S_ERROR;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_READ_WAIT: begin
                    if (!reader_busy) begin
                        cur_state <= S_DRAIN;
                    end else if (timed_out) begin
                        cur_state <= S_ERROR;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        cur_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (blk_cnt == LAST_BLK) begin
                        cur_state <= S_DONE;
                    end else begin
                        block_addr <= block_addr + STEP_W;
                        blk_cnt    <= blk_cnt + 8'd1;
                        cur_state  <= S_READ_START;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        cur_state <= S_IDLE;
                    end
                end
                default: cur_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of control outputs and the bus mux; only one engine ever reaches the card.
    always_comb begin
        sub_reset    = 1'b0;
        init_start   = 1'b0;
        reader_start = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        CS           = 1'b1;
        MOSI         = 1'b1;
        case (cur_state)
            S_IDLE: begin
                sub_reset = 1'b1;
                busy      = 1'b0;
            end
            S_SUBRST: sub_reset = 1'b1;
            S_INIT_START: begin
                init_start = 1'b1;
                CS         = init_CS;
                MOSI       = init_MOSI;
            end
            S_INIT_WAIT: begin
                CS   = init_CS;
                MOSI = init_MOSI;
            end
            S_READ_START: begin
                reader_start = 1'b1;
                CS           = reader_CS;
                MOSI         = reader_MOSI;
            end
            S_READ_ARM, S_READ_WAIT: begin
                CS   = reader_CS;
                MOSI = reader_MOSI;
            end
            S_DONE: begin
                sub_reset = 1'b1;
                busy      = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: begin
                sub_reset = 1'b1;
                busy      = 1'b0;
                error     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_spi_sequencer.sv
// Bench for sd_spi_sequencer: emulates the initializer, reader and UART FIFO,
// checks the pin decode every cycle and whole-session outcomes per scenario.
module tb_sd_spi_sequencer;

    localparam int T   = 50;
    localparam int MR  = 3;
    localparam int NB  = 4;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_READ_ARM = 4'd5;
    localparam logic [3:0] ST_RWAIT    = 4'd6;
    localparam logic [3:0] ST_DRAIN    = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd9;
    localparam logic [3:0] ST_ERROR    = 4'd15;

    typedef struct {
        int f;
        int cr;
        int a;
        int b;
        int d;
        int spurious;
        bit expDone;
        int expTicks;
        int expReads;
        int expInits;
    } row_t;

    logic        d_clock;
    logic        reset_PB_down;
    logic        start, card_ready, init_MOSI, init_CS, reader_MOSI, reader_CS, reader_busy, fifo_empty;
    logic        sub_reset, init_start, reader_start, CS, MOSI, busy, done, error;
    logic [31:0] block_addr;
    logic [3:0]  state;

    logic        start2, card_ready2, fifo_empty2, reader_busy2, busMosi2, busCs2;
    logic        sub_reset2, init_start2, reader_start2, CS2, MOSI2, busy2, done2, error2;
    logic [9:0]  block_addr2;
    logic [3:0]  state2;

    int vectors = 0;
    int miscompares = 0;

    int sF, sCr, sA, sB, sD;
    int icnt, rcnt, dcnt, attemptIdx, nInits, nReads;
    bit initArmed, readerActive;
    logic [31:0] addrQ[$];
    logic [9:0]  addrQ2[$];

    row_t rows[8];

    sd_spi_sequencer #(
        .NUM_BLOCKS(NB), .ADDR_WIDTH(32), .START_ADDR(32'd0),
        .ADDR_STEP(512), .TIMEOUT(T), .MAX_RETRIES(MR)
    ) dut (
        .d_clock(d_clock), .reset_PB_down(reset_PB_down), .start(start),
        .card_ready(card_ready), .init_MOSI(init_MOSI), .init_CS(init_CS),
        .reader_MOSI(reader_MOSI), .reader_CS(reader_CS), .reader_busy(reader_busy),
        .fifo_empty(fifo_empty), .sub_reset(sub_reset), .init_start(init_start),
        .reader_start(reader_start), .block_addr(block_addr), .CS(CS), .MOSI(MOSI),
        .busy(busy), .done(done), .error(error), .state(state)
    );

    sd_spi_sequencer #(
        .NUM_BLOCKS(3), .ADDR_WIDTH(10), .START_ADDR(10'd512),
        .ADDR_STEP(384), .TIMEOUT(T), .MAX_RETRIES(MR)
    ) dut2 (
        .d_clock(d_clock), .reset_PB_down(reset_PB_down), .start(start2),
        .card_ready(card_ready2), .init_MOSI(busMosi2), .init_CS(busCs2),
        .reader_MOSI(busMosi2), .reader_CS(busCs2), .reader_busy(reader_busy2),
        .fifo_empty(fifo_empty2), .sub_reset(sub_reset2), .init_start(init_start2),
        .reader_start(reader_start2), .block_addr(block_addr2), .CS(CS2), .MOSI(MOSI2),
        .busy(busy2), .done(done2), .error(error2), .state(state2)
    );

    // Free-running d_clock, 10 time units per period.
    initial begin
        d_clock = 1'b0;
        forever #5 d_clock = ~d_clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pin values the session rules imply for a given state and engine bus levels.
    function automatic logic [7:0] expectPins(input logic [3:0] s, input logic ics, input logic imo,
                                              input logic rcs, input logic rmo);
        logic sr, bz, cs, mo;
        sr = (s == 4'd0) || (s == 4'd1) || (s == 4'd9) || (s == 4'd15);
        bz = !((s == 4'd0) || (s == 4'd9) || (s == 4'd15));
        if (s == 4'd2 || s == 4'd3) begin
            cs = ics; mo = imo;
        end else if (s >= 4'd4 && s <= 4'd6) begin
            cs = rcs; mo = rmo;
        end else begin
            cs = 1'b1; mo = 1'b1;
        end
        return {sr, s == 4'd2, s == 4'd4, bz, s == 4'd9, s == 4'd15, cs, mo};
    endfunction

    // Session-level prediction from per-state cycle costs: each failed init attempt
    // spends T+1 cycles waiting, each block costs start+arm+busy+drain+next.
    function automatic row_t model(input int f, input int cr, input int a, input int b,
                                   input int d, input int spur);
        row_t r;
        int   initCost;
        r = '{f: f, cr: cr, a: a, b: b, d: d, spurious: spur,
              expDone: 1'b0, expTicks: 0, expReads: 0, expInits: 0};
        if (f > MR || cr > T + 1) begin
            r.expInits = MR + 1;
            r.expTicks = (MR + 1) * (T + 3);
            return r;
        end
        r.expInits = f + 1;
        initCost   = 2 * (f + 1) + f * (T + 1) + cr;
        if (a > T + 1) begin
            r.expReads = 1;
            r.expTicks = initCost + 1 + (T + 1);
        end else if (b > T + 1) begin
            r.expReads = 1;
            r.expTicks = initCost + 1 + a + (T + 1);
        end else begin
            r.expDone  = 1'b1;
            r.expReads = NB;
            r.expTicks = initCost + NB * (a + b + d + 3);
        end
        return r;
    endfunction

    // One clock: observe the DUTs after the edge, update engine emulation, drive new bus levels.
    task automatic tick();
        @(posedge d_clock);
        #1;
        if (sub_reset) begin
            initArmed    = 1'b0;
            readerActive = 1'b0;
        end
        if (init_start) begin
            initArmed  = 1'b1;
            icnt       = 0;
            attemptIdx = nInits;
            nInits++;
        end else if (initArmed) begin
            icnt++;
        end
        card_ready = initArmed && (attemptIdx >= sF) && (icnt >= sCr);
        if (reader_start) begin
            readerActive = 1'b1;
            rcnt         = 0;
            dcnt         = 0;
            nReads++;
            addrQ.push_back(block_addr);
            fifo_empty = (sD == 0);
        end else begin
            if (readerActive) rcnt++;
            if (state == ST_DRAIN) begin
                fifo_empty = (dcnt >= sD);
                dcnt++;
            end
        end
        reader_busy  = readerActive && (rcnt >= sA) && (rcnt < sA + sB);
        reader_busy2 = (state2 == ST_READ_ARM);
        if (reader_start2) addrQ2.push_back(block_addr2);
        init_CS     = 1'($urandom);
        init_MOSI   = 1'($urandom);
        reader_CS   = 1'($urandom);
        reader_MOSI = 1'($urandom);
        #1;
        checkOutput("pins", 64'({sub_reset, init_start, reader_start, busy, done, error, CS, MOSI}),
                    64'(expectPins(state, init_CS, init_MOSI, reader_CS, reader_MOSI)));
    endtask

    task automatic applyStimulus(input int f, input int cr, input int a, input int b, input int d,
                                 input int spur, output int ticks);
        sF = f; sCr = cr; sA = a; sB = b; sD = d;
        nInits = 0;
        nReads = 0;
        addrQ.delete();
        fifo_empty = 1'b1;
        if (state == ST_DONE || state == ST_ERROR) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            checkOutput("leave_terminal", 64'(state), 64'(ST_IDLE));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks = 0;
        while (!(state == ST_DONE || state == ST_ERROR) && ticks < 8000) begin
            ticks++;
            if (ticks == spur) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic runRow(input row_t r, input string tag);
        int ticks;
        applyStimulus(r.f, r.cr, r.a, r.b, r.d, r.spurious, ticks);
        checkOutput({tag, "_end"}, 64'(state), r.expDone ? 64'(ST_DONE) : 64'(ST_ERROR));
        checkOutput({tag, "_ticks"}, 64'(ticks), 64'(r.expTicks));
        checkOutput({tag, "_reads"}, 64'(nReads), 64'(r.expReads));
        checkOutput({tag, "_inits"}, 64'(nInits), 64'(r.expInits));
        for (int i = 0; i < nReads && i < r.expReads; i++)
            checkOutput({tag, "_addr"}, 64'(addrQ[i]), 64'(i * 512));
        if (r.expDone) checkOutput({tag, "_done_bus"}, 64'({busy, CS, MOSI}), 64'(3'b011));
    endtask

    initial begin
        int   guard;
        row_t r;

        rows[0] = '{f: 0, cr: 20, a: 3,  b: 20,   d: 0,   spurious: 5,  expDone: 1, expTicks: 126,  expReads: 4, expInits: 1};
        rows[1] = '{f: 0, cr: 51, a: 1,  b: 1,    d: 0,   spurious: 0,  expDone: 1, expTicks: 73,   expReads: 4, expInits: 1};
        rows[2] = '{f: 0, cr: 52, a: 1,  b: 1,    d: 0,   spurious: 10, expDone: 0, expTicks: 212,  expReads: 0, expInits: 4};
        rows[3] = '{f: 2, cr: 10, a: 2,  b: 51,   d: 3,   spurious: 0,  expDone: 1, expTicks: 354,  expReads: 4, expInits: 3};
        rows[4] = '{f: 3, cr: 5,  a: 60, b: 1,    d: 0,   spurious: 0,  expDone: 0, expTicks: 218,  expReads: 1, expInits: 4};
        rows[5] = '{f: 4, cr: 5,  a: 1,  b: 1,    d: 0,   spurious: 0,  expDone: 0, expTicks: 212,  expReads: 0, expInits: 4};
        rows[6] = '{f: 0, cr: 1,  a: 1,  b: 52,   d: 0,   spurious: 3,  expDone: 0, expTicks: 56,   expReads: 1, expInits: 1};
        rows[7] = '{f: 0, cr: 3,  a: 2,  b: 5,    d: 300, spurious: 40, expDone: 1, expTicks: 1245, expReads: 4, expInits: 1};

        reset_PB_down = 1'b1;
        start = 1'b0; card_ready = 1'b0; init_MOSI = 1'b1; init_CS = 1'b1;
        reader_MOSI = 1'b1; reader_CS = 1'b1; reader_busy = 1'b0; fifo_empty = 1'b1;
        start2 = 1'b0; card_ready2 = 1'b1; fifo_empty2 = 1'b1; reader_busy2 = 1'b0;
        busMosi2 = 1'b1; busCs2 = 1'b1;
        sF = 0; sCr = 1; sA = 1; sB = 1; sD = 0;
        icnt = 0; rcnt = 0; dcnt = 0; attemptIdx = 0; nInits = 0; nReads = 0;
        initArmed = 1'b0; readerActive = 1'b0;

        repeat (3) tick();
        checkOutput("reset_state", 64'(state), 64'(ST_IDLE));
        checkOutput("reset_addr", 64'(block_addr), 64'd0);
        checkOutput("reset_pins", 64'({sub_reset, init_start, reader_start, busy, done, error, CS, MOSI}),
                    64'(8'b1000_0011));
        reset_PB_down = 1'b0;

        // Narrow-address instance: third block address wraps past 2^10.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        guard = 0;
        while (state2 != ST_DONE && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("wrap_done", 64'(state2), 64'(ST_DONE));
        checkOutput("wrap_reads", 64'(addrQ2.size()), 64'd3);
        if (addrQ2.size() == 3) begin
            checkOutput("wrap_addr0", 64'(addrQ2[0]), 64'd512);
            checkOutput("wrap_addr1", 64'(addrQ2[1]), 64'd896);
            checkOutput("wrap_addr2", 64'(addrQ2[2]), 64'd256);
        end

        for (int i = 0; i < 8; i++) runRow(rows[i], $sformatf("row%0d", i));

        // Asynchronous reset in the middle of a block read.
        r = model(0, 1, 1, 1000, 0, 0);
        sF = 0; sCr = 1; sA = 1; sB = 1000; sD = 0;
        if (state == ST_DONE || state == ST_ERROR) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (state != ST_RWAIT && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("reach_read_wait", 64'(state), 64'(ST_RWAIT));
        repeat (5) tick();
        #1;
        reset_PB_down = 1'b1;
        #1;
        checkOutput("async_state", 64'(state), 64'(ST_IDLE));
        checkOutput("async_cs", 64'(CS), 64'd1);
        checkOutput("async_subrst", 64'(sub_reset), 64'd1);
        checkOutput("async_done", 64'(done), 64'd0);
        repeat (2) tick();
        reset_PB_down = 1'b0;
        tick();
        runRow(rows[0], "rerun");
        checkOutput("model_wait_err", 64'(r.expDone), 64'd0);

        for (int i = 0; i < 10; i++) begin
            int f, cr, a, b, d;
            f  = int'($urandom_range(0, 4));
            cr = int'($urandom_range(1, 55));
            a  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(52, 60)) : int'($urandom_range(1, 10));
            b  = int'($urandom_range(1, 55));
            d  = int'($urandom_range(0, 20));
            runRow(model(f, cr, a, b, d, int'($urandom_range(1, 30))), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
